// File: rtl/conv3d_channel_reduce_pkg.sv
// Shared constants and helpers for the conv3d channel-reduce stage.
// Holds FP32 constants, tree sizing helpers and the FP32 add core.
package conv3d_channel_reduce_pkg;

    localparam logic [31:0] FP_ZERO     = 32'h0000_0000;
    localparam logic [31:0] FP_SIGN_BIT = 32'h8000_0000;
    localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) r++;
        return r;
    endfunction

    // operands present at tree level lvl (level 0 = channel inputs)
    function automatic int ops_at(input int ch, input int lvl);
        int n;
        n = ch;
        for (int i = 0; i < lvl; i++) n = (n + 1) / 2;
        return n;
    endfunction

    // first index of level lvl in the flattened operand array
    function automatic int base_at(input int ch, input int lvl);
        int b;
        b = 0;
        for (int i = 0; i < lvl; i++) b = b + ops_at(ch, i);
        return b;
    endfunction

    // IEEE-754 single add, round-to-nearest-even, subnormals kept
    function automatic logic [31:0] fp32_add(input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] x;
        logic [31:0] y;
        logic [7:0]  ex;
        logic [7:0]  ey;
        logic [7:0]  d;
        logic [27:0] mx;
        logic [27:0] my;
        logic [27:0] ms;
        logic [27:0] mask;
        logic [9:0]  er;
        logic [24:0] rm;
        logic        up;
        if (a[30:0] >= b[30:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        if (x[30:23] == 8'hFF) begin
            if (x[22:0] != 23'd0) return FP_QNAN;
            if (y[30:23] == 8'hFF && x[31] != y[31]) return FP_QNAN;
            return x;
        end
        ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
        ey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
        mx = {1'b0, x[30:23] != 8'd0, x[22:0], 3'b000};
        my = {1'b0, y[30:23] != 8'd0, y[22:0], 3'b000};
        d  = ex - ey;
        if (d > 8'd26) begin
            my = {27'd0, |my};
        end else begin
            mask = (28'd1 << d) - 28'd1;
            my   = (my >> d) | {27'd0, |(my & mask)};
        end
        er = {2'b00, ex};
        if (x[31] == y[31]) begin
            ms = mx + my;
            if (ms[27]) begin
                ms = {1'b0, ms[27:2], ms[1] | ms[0]};
                er = er + 10'd1;
            end
        end else begin
            ms = mx - my;
            if (ms == 28'd0) return FP_ZERO;
            for (int i = 0; i < 26; i++) begin
                if (!ms[26] && er > 10'd1) begin
                    ms = ms << 1;
                    er = er - 10'd1;
                end
            end
        end
        up = ms[2] & (ms[1] | ms[0] | ms[3]);
        rm = {1'b0, ms[26:3]} + {24'd0, up};
        if (rm[24]) begin
            rm = rm >> 1;
            er = er + 10'd1;
        end
        if (er >= 10'd255) return {x[31], 8'hFF, 23'd0};
        return {x[31], rm[23] ? er[7:0] : 8'd0, rm[22:0]};
    endfunction

endpackage

// File: rtl/conv3d_channel_reduce_fp_add_pipe.sv
// Pipelined FP32 adder node with a travelling valid, plus the
// plain delay line used to keep odd tree operands aligned.
module fp_add_pipe #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_sum
);
    import conv3d_channel_reduce_pkg::*;

    logic [DATA_WIDTH-1:0]  w_sum;
    logic [DATA_WIDTH-1:0]  r_data [ADD_LATENCY];
    logic [ADD_LATENCY-1:0] r_valid;

    assign w_sum = fp32_add(i_a, i_b);

    // stage registers; data only moves with its valid so results hold
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            for (int s = 0; s < ADD_LATENCY; s++) r_data[s] <= FP_ZERO;
        end else begin
            r_valid[0] <= i_valid;
            if (i_valid) r_data[0] <= w_sum;
            for (int s = 1; s < ADD_LATENCY; s++) begin
                r_valid[s] <= r_valid[s-1];
                if (r_valid[s-1]) r_data[s] <= r_data[s-1];
            end
        end
    end

    assign o_valid = r_valid[ADD_LATENCY-1];
    assign o_sum   = r_data[ADD_LATENCY-1];

endmodule

module delay_clock #(
    parameter int WIDTH = 32,
    parameter int DELAY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);
    logic [WIDTH-1:0] r_pipe [DELAY];

    // fixed-length shift line, cleared so reset leaves nothing pending
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < DELAY; s++) r_pipe[s] <= '0;
        end else begin
            r_pipe[0] <= i_data;
            for (int s = 1; s < DELAY; s++) r_pipe[s] <= r_pipe[s-1];
        end
    end

    assign o_data = r_pipe[DELAY-1];

endmodule

// File: rtl/conv3d_channel_reduce.sv
// Multi-channel FP32 reduction tree + bias add with frame tracking.
// Optional ReLU output register: define CONV3D_RELU_OUT_EN.
module conv3d_channel_reduce #(
    parameter int DATA_WIDTH  = 32,
    parameter int CHANNEL     = 3,
    parameter int IMG_WIDTH   = 56,
    parameter int IMG_HEIGHT  = 56,
    parameter int ADD_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [CHANNEL-1:0]            valid_in,
    input  logic [CHANNEL*DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0]         bias,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          valid_out,
    output logic                          done,
    output logic [31:0]                   pixel_count,
    output logic                          align_err
);
    import conv3d_channel_reduce_pkg::*;

    localparam int LEVELS = clog2(CHANNEL);
    localparam int N_OPS  = base_at(CHANNEL, LEVELS + 1);
    localparam logic [31:0] LAST_PIX = 32'(IMG_WIDTH * IMG_HEIGHT - 1);

    logic [DATA_WIDTH-1:0] w_ops [N_OPS];
    logic [LEVELS:0]       w_lv;
    logic                  w_accept;
    logic                  w_misalign;
    logic                  w_bval;
    logic [DATA_WIDTH-1:0] w_bsum;
    logic [31:0]           r_pix;
    logic                  r_align_err;

    assign w_accept   = &valid_in;
    assign w_misalign = (|valid_in) & ~w_accept;
    assign w_lv[0]    = w_accept;

    for (genvar c = 0; c < CHANNEL; c++) begin : g_in
        assign w_ops[c] = data_in[c*DATA_WIDTH +: DATA_WIDTH];
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int NI = ops_at(CHANNEL, l);
        localparam int BI = base_at(CHANNEL, l);
        localparam int BO = base_at(CHANNEL, l + 1);
        localparam int NP = NI / 2;

        logic [NP-1:0] w_nv;

        for (genvar j = 0; j < NP; j++) begin : g_node
            fp_add_pipe #(
                .DATA_WIDTH (DATA_WIDTH),
                .ADD_LATENCY(ADD_LATENCY)
            ) u_add (
                .clk    (clk),
                .reset  (reset),
                .i_valid(w_lv[l]),
                .i_a    (w_ops[BI+2*j]),
                .i_b    (w_ops[BI+2*j+1]),
                .o_valid(w_nv[j]),
                .o_sum  (w_ops[BO+j])
            );
        end

        if (NI % 2 == 1) begin : g_odd
            delay_clock #(
                .WIDTH(DATA_WIDTH),
                .DELAY(ADD_LATENCY)
            ) u_dly (
                .clk   (clk),
                .reset (reset),
                .i_data(w_ops[BI+NI-1]),
                .o_data(w_ops[BO+NP])
            );
        end

        assign w_lv[l+1] = &w_nv;
    end

    fp_add_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADD_LATENCY(ADD_LATENCY)
    ) u_bias (
        .clk    (clk),
        .reset  (reset),
        .i_valid(w_lv[LEVELS]),
        .i_a    (w_ops[N_OPS-1]),
        .i_b    (bias),
        .o_valid(w_bval),
        .o_sum  (w_bsum)
    );

`ifdef CONV3D_RELU_OUT_EN
    logic                  r_relu_valid;
    logic [DATA_WIDTH-1:0] r_relu_data;

    // ReLU output register: negative results clamp to +0
    always_ff @(posedge clk) begin
        if (reset) begin
            r_relu_valid <= 1'b0;
            r_relu_data  <= FP_ZERO;
        end else begin
            r_relu_valid <= w_bval;
            if (w_bval) begin
                r_relu_data <= ((w_bsum & FP_SIGN_BIT) != FP_ZERO) ?
                               FP_ZERO : w_bsum;
            end
        end
    end

    assign valid_out = r_relu_valid;
    assign data_out  = r_relu_data;
`else
    assign valid_out = w_bval;
    assign data_out  = w_bsum;
`endif

    // pixel position in the frame and sticky misalignment flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pix       <= 32'd0;
            r_align_err <= 1'b0;
        end else begin
            if (w_misalign) r_align_err <= 1'b1;
            if (valid_out) r_pix <= (r_pix == LAST_PIX) ? 32'd0 : r_pix + 32'd1;
        end
    end

    assign done        = valid_out & (r_pix == LAST_PIX);
    assign pixel_count = r_pix;
    assign align_err   = r_align_err;

endmodule

// File: tb/tb_conv3d_channel_reduce.sv
// Directed bench for conv3d_channel_reduce: CHANNEL=3, 4 and 1 builds.
// Honours CONV3D_RELU_OUT_EN for expected latency and clamping.
`timescale 1ns/1ps
module tb_conv3d_channel_reduce;

`ifdef CONV3D_RELU_OUT_EN
    localparam int RELU = 1;
`else
    localparam int RELU = 0;
`endif
    localparam int LAT_A = 3 + RELU;
    localparam int LAT_B = 3 + RELU;
    localparam int LAT_C = 2 + RELU;

    localparam logic [31:0] F1   = 32'h3F80_0000;
    localparam logic [31:0] F2   = 32'h4000_0000;
    localparam logic [31:0] F3   = 32'h4040_0000;
    localparam logic [31:0] FH   = 32'h3F00_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]   a_vin;
    logic [95:0]  a_din;
    logic [31:0]  a_bias, a_dout, a_pix;
    logic         a_vout, a_done, a_err;

    logic [3:0]   b_vin;
    logic [127:0] b_din;
    logic [31:0]  b_bias, b_dout, b_pix;
    logic         b_vout, b_done, b_err;

    logic [0:0]   c_vin;
    logic [31:0]  c_din;
    logic [31:0]  c_bias, c_dout, c_pix;
    logic         c_vout, c_done, c_err;

    conv3d_channel_reduce #(.CHANNEL(3), .IMG_WIDTH(2), .IMG_HEIGHT(2),
                            .ADD_LATENCY(1)) u_a (
        .clk(clk), .reset(reset), .valid_in(a_vin), .data_in(a_din),
        .bias(a_bias), .data_out(a_dout), .valid_out(a_vout),
        .done(a_done), .pixel_count(a_pix), .align_err(a_err));

    conv3d_channel_reduce #(.CHANNEL(4), .IMG_WIDTH(2), .IMG_HEIGHT(2),
                            .ADD_LATENCY(1)) u_b (
        .clk(clk), .reset(reset), .valid_in(b_vin), .data_in(b_din),
        .bias(b_bias), .data_out(b_dout), .valid_out(b_vout),
        .done(b_done), .pixel_count(b_pix), .align_err(b_err));

    conv3d_channel_reduce #(.CHANNEL(1), .ADD_LATENCY(2)) u_c (
        .clk(clk), .reset(reset), .valid_in(c_vin), .data_in(c_din),
        .bias(c_bias), .data_out(c_dout), .valid_out(c_vout),
        .done(c_done), .pixel_count(c_pix), .align_err(c_err));

    typedef struct {
        logic [31:0] d0, d1, d2, bias, res;
    } vec_t;

    vec_t tv [8];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] relu(input logic [31:0] x);
        if (RELU != 0 && x[31]) return 32'h0;
        return x;
    endfunction

    logic [31:0] b_in  [5];
    logic [31:0] b_res [5];

    initial begin
        tv[0] = '{F1, F2, F3, FH, 32'h40D0_0000};
        tv[1] = '{F1, 32'h3380_0000, 32'h0, 32'h0, F1};
        tv[2] = '{32'hBF80_0000, F1, F2, 32'h0, F2};
        tv[3] = '{FH, 32'h3E80_0000, 32'h3E80_0000, F1, F2};
        tv[4] = '{32'h4120_0000, 32'hC020_0000, 32'h0, 32'hBF00_0000,
                  32'h40E0_0000};
        tv[5] = '{32'hBF80_0000, 32'hBF80_0000, 32'hC000_0000, 32'h0,
                  32'hC080_0000};
        tv[6] = '{32'h3FC0_0000, 32'h4010_0000, 32'h42C8_0000,
                  32'h3E00_0000, 32'h42CF_C000};
        tv[7] = '{F1, 32'h33C0_0000, 32'h0, 32'h0, 32'h3F80_0001};
        b_in  = '{F1, F2, F3, 32'h4080_0000, 32'h40A0_0000};
        b_res = '{32'h4090_0000, 32'h40B0_0000, 32'h40D0_0000,
                  32'h40F0_0000, 32'h4108_0000};

        a_vin = '0; a_din = '0; a_bias = '0;
        b_vin = '0; b_din = '0; b_bias = '0;
        c_vin = '0; c_din = '0; c_bias = '0;

        reset = 1'b1;
        repeat (2) tick();
        chk("rst_a_vout", a_vout, 0);
        chk("rst_a_dout", a_dout, 0);
        chk("rst_a_pix", a_pix, 0);
        chk("rst_a_done", a_done, 0);
        chk("rst_a_err", a_err, 0);
        chk("rst_b_vout", b_vout, 0);
        chk("rst_c_vout", c_vout, 0);
        reset = 1'b0;
        tick();

        // table of single beats on the 3-channel build
        for (int i = 0; i < 8; i++) begin
            a_din  = {tv[i].d2, tv[i].d1, tv[i].d0};
            a_bias = tv[i].bias;
            a_vin  = 3'b111;
            for (int k = 1; k <= LAT_A; k++) begin
                tick();
                a_vin = 3'b000;
                if (k < LAT_A)
                    chk($sformatf("v%0d_early%0d", i, k), a_vout, 0);
            end
            chk($sformatf("v%0d_vout", i), a_vout, 1);
            chk($sformatf("v%0d_data", i), a_dout, relu(tv[i].res));
            chk($sformatf("v%0d_pix", i), a_pix, i % 4);
            chk($sformatf("v%0d_done", i), a_done, (i % 4 == 3) ? 1 : 0);
            tick();
            chk($sformatf("v%0d_idle", i), a_vout, 0);
            chk($sformatf("v%0d_hold", i), a_dout, relu(tv[i].res));
        end
        chk("a_wrap_pix", a_pix, 0);
        chk("a_no_err", a_err, 0);

        // partial valid drops the beat and latches align_err
        a_din = {F3, F2, F1};
        a_bias = FH;
        a_vin = 3'b101;
        tick();
        a_vin = 3'b000;
        chk("mis_err_set", a_err, 1);
        for (int k = 0; k <= LAT_A; k++) begin
            tick();
            chk($sformatf("mis_novalid%0d", k), a_vout, 0);
        end
        a_vin = 3'b111;
        for (int k = 1; k <= LAT_A; k++) begin
            tick();
            a_vin = 3'b000;
        end
        chk("mis_next_vout", a_vout, 1);
        chk("mis_next_data", a_dout, 32'h40D0_0000);
        chk("mis_next_pix", a_pix, 0);
        chk("mis_err_held", a_err, 1);
        tick();
        chk("mis_err_held2", a_err, 1);

        // 4-channel 2x2 frame streamed back to back, then one more
        b_bias = FH;
        for (int cyc = 0; cyc < 5 + LAT_B; cyc++) begin
            int idx;
            if (cyc < 5) begin
                b_din = {F1, F1, F1, b_in[cyc]};
                b_vin = 4'hF;
            end else begin
                b_vin = 4'h0;
            end
            tick();
            idx = cyc + 1 - LAT_B;
            if (idx >= 0 && idx < 5) begin
                chk($sformatf("b%0d_vout", idx), b_vout, 1);
                chk($sformatf("b%0d_data", idx), b_dout, b_res[idx]);
                chk($sformatf("b%0d_pix", idx), b_pix, idx % 4);
                chk($sformatf("b%0d_done", idx), b_done, (idx == 3) ? 1 : 0);
            end else begin
                chk($sformatf("b_c%0d_idle", cyc), b_vout, 0);
            end
        end
        chk("b_pix_after", b_pix, 1);

        // single-channel build: only the bias stage
        c_din = F2;
        c_bias = F1;
        c_vin = 1'b1;
        for (int k = 1; k <= LAT_C; k++) begin
            tick();
            c_vin = 1'b0;
            if (k < LAT_C) chk($sformatf("c0_early%0d", k), c_vout, 0);
        end
        chk("c0_vout", c_vout, 1);
        chk("c0_data", c_dout, F3);
        chk("c0_pix", c_pix, 0);
        c_din = 32'hC080_0000;
        c_bias = 32'h0;
        c_vin = 1'b1;
        for (int k = 1; k <= LAT_C; k++) begin
            tick();
            c_vin = 1'b0;
        end
        chk("c1_vout", c_vout, 1);
        chk("c1_data", c_dout, relu(32'hC080_0000));
        chk("c1_pix", c_pix, 1);

        // reset with two beats in flight on the 3-channel build
        chk("pre_rst_pix", a_pix, 1);
        a_din = {F1, F1, F1};
        a_bias = 32'h0;
        a_vin = 3'b111;
        tick();
        tick();
        a_vin = 3'b000;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_vout", a_vout, 0);
        chk("mid_rst_done", a_done, 0);
        chk("mid_rst_pix", a_pix, 0);
        chk("mid_rst_err", a_err, 0);
        chk("mid_rst_dout", a_dout, 0);
        for (int k = 0; k < LAT_A + 3; k++) begin
            tick();
            chk($sformatf("no_stale%0d", k), a_vout, 0);
        end
        a_vin = 3'b111;
        for (int k = 1; k <= LAT_A; k++) begin
            tick();
            a_vin = 3'b000;
        end
        chk("post_rst_vout", a_vout, 1);
        chk("post_rst_data", a_dout, F3);
        chk("post_rst_pix", a_pix, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv3d_channel_reduce.md
Name: conv3d_channel_reduce

Overview:
Parametrised multi-channel reduction stage for 3D convolution. Takes CHANNEL aligned per-channel 2D-kernel partial-sum streams, sums them in a pipelined balanced FP32 adder tree, adds a per-filter bias, and emits one output pixel per accepted input beat. It tracks pixel position within an IMG_WIDTH x IMG_HEIGHT frame, pulses done on the last pixel, and flags channel-valid misalignment. It sits between the per-channel conv2d kernel array and the layer output/activation path.

Parameters:
DATA_WIDTH, 32, word width (IEEE-754 single; only 32 supported)
CHANNEL, 3, number of input channels, >=1
IMG_WIDTH, 56, output frame width in pixels
IMG_HEIGHT, 56, output frame height in pixels
ADD_LATENCY, 1, fixed cycles per FP add stage, >=1

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
valid_in  in  CHANNEL  per-channel valid, bit c for channel c
data_in  in  CHANNEL*DATA_WIDTH  channel c at bits [c*DATA_WIDTH +: DATA_WIDTH]
bias  in  DATA_WIDTH  filter bias; must be stable for a whole frame
data_out  out  DATA_WIDTH  result pixel
valid_out  out  1  data_out valid this cycle
done  out  1  one-cycle pulse with the last pixel of a frame
pixel_count  out  32  index of the next pixel to be output
align_err  out  1  sticky channel-misalignment flag

Behaviour:
- Reset (synchronous, active-high) clears all pipeline valids, data_out, valid_out, done, pixel_count and align_err to 0, and drops any in-flight data. Reset mid-frame leaves nothing pending.
- Accept: a beat is accepted when valid_in is all-ones. No backpressure. Back-to-back beats run at one pixel per cycle.
- Misalignment: valid_in neither all-zero nor all-ones drops that beat and sets align_err. align_err stays set until reset.
- Tree: LEVELS = clog2(CHANNEL). Level k pairs adjacent operands. An odd trailing operand goes through an ADD_LATENCY-cycle delay register so all operands at the next level stay aligned. CHANNEL=1 has no tree.
- Valid travels alongside data, one registered valid per add stage.
- Bias add: one final FP add stage, operand B = bias.
- Latency from accepted beat to valid_out = (LEVELS+1)*ADD_LATENCY cycles, plus 1 if RELU_OUT_EN is defined. Latency is constant.
- Sum order is fixed (pairwise, channel 0 leftmost), so results are bit-reproducible.
- Counter: pixel_count increments on each valid_out. When valid_out occurs with pixel_count == IMG_WIDTH*IMG_HEIGHT-1, done=1 in that same cycle and pixel_count wraps to 0 next cycle.
- A new frame may follow the last pixel with no gap.
- data_out holds its last value when valid_out=0.

Optional Feature:
- Macro: CONV3D_RELU_OUT_EN.
- Defined: one extra output register applies ReLU. If the sign bit is 1, data_out = 0x00000000; otherwise the value passes unchanged. Latency +1 cycle, and done/pixel_count follow the delayed valid_out.
- Undefined: raw biased sum is output, no extra stage.

Decomposition:
- Shared package holds: FP32 constants (FP_ZERO, FP_SIGN_BIT), a clog2 function, and localparam helpers for LEVELS and operand count per level.
- One natural sub-module: fp_add_pipe. It wraps the team FP add core with a registered valid and guaranteed ADD_LATENCY. It is instantiated per tree node and for the bias stage.
- Odd-operand delays use the existing delay_clock block.

Test Plan:
- CHANNEL=3, ADD_LATENCY=1: inputs 1.0, 2.0, 3.0 (0x3F800000, 0x40000000, 0x40400000), bias 0.5 (0x3F000000) -> data_out 0x40D00000 (6.5), valid_out exactly 3 cycles after the beat.
- CHANNEL=4, IMG 2x2: four back-to-back beats -> four consecutive valid_out, done high only with the fourth, pixel_count 0,1,2,3 then 0. A fifth beat continues at pixel_count 0.
- CHANNEL=1: input 0x40000000, bias 0x3F800000 -> 0x40400000 after ADD_LATENCY cycles.
- Misalignment: valid_in=3'b101 for one cycle -> no valid_out for that slot, align_err=1 and held. The next all-ones beat is output normally.
- Reset asserted while 2 beats are in flight -> valid_out, done, pixel_count and align_err all 0 the next cycle, and no stale pixels emerge.
- CONV3D_RELU_OUT_EN defined, inputs summing to -4.0 plus bias 0 -> data_out 0x00000000, latency = base + 1.
